// File: rtl/axi_stream_downsizer_pkg.sv
// Shared helpers for the AXI-Stream downsizer: width math, slice-index sizing, FSM states.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: not applicable.
package axi_stream_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_BUSY  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Guard against a zero output width so a bad configuration still elaborates far
   // enough to hit the width check instead of dividing by zero.
   function automatic int ratio(input int in_bytes, input int out_bytes);
      return (out_bytes > 0) ? (in_bytes / out_bytes) : 1;
   endfunction

   function automatic int idx_width(input int r);
      return (clog2(r) < 1) ? 1 : clog2(r);
   endfunction

   function automatic bit widths_ok(input int in_bytes, input int out_bytes);
      return (out_bytes > 0) && (in_bytes > 0) && ((in_bytes % out_bytes) == 0);
   endfunction

   // Zero-width sidebands are carried as a single bit that is driven to zero.
   function automatic int side_width(input int w);
      return (w > 0) ? w : 1;
   endfunction

endpackage

// File: rtl/axi_stream_downsizer_if.sv
// AXI4-Stream bundle shared by the wide slave side and the narrow master side.
// Latency: none (wires only).
// Backpressure: tready flows from slave modport to master modport.
interface axi_stream_downsizer_if
   import axi_stream_pkg::*;
#(
   parameter int BYTE_WIDTH = 1,
   parameter int ID_WIDTH   = 0,
   parameter int DEST_WIDTH = 0,
   parameter int USER_WIDTH = 0
);
   localparam int IW = side_width(ID_WIDTH);
   localparam int DW = side_width(DEST_WIDTH);
   localparam int UW = side_width(USER_WIDTH);

   logic                    tvalid;
   logic                    tready;
   logic [8*BYTE_WIDTH-1:0] tdata;
   logic [BYTE_WIDTH-1:0]   tstrb;
   logic [BYTE_WIDTH-1:0]   tkeep;
   logic                    tlast;
   logic [IW-1:0]           tid;
   logic [DW-1:0]           tdest;
   logic [UW-1:0]           tuser;

   modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                   input  tready);
   modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                   output tready);
endinterface

// File: rtl/axis_slice_finder.sv
// Finds the lowest, next-above-idx and highest occupied slice of a wide beat.
// Latency: combinational.
// Backpressure: not applicable.
module axis_slice_finder #(
   parameter int RATIO = 4,
   parameter int IDXW  = 2
) (
   input  logic [RATIO-1:0] nz_i,
   input  logic [IDXW-1:0]  idx_i,
   output logic [IDXW-1:0]  first_o,
   output logic [IDXW-1:0]  next_o,
   output logic [IDXW-1:0]  final_o
);
   logic found_first;
   logic found_next;

   // Priority scan; an empty beat reports the top slice so tlast still has a carrier.
   always_comb begin
      first_o     = IDXW'(RATIO - 1);
      next_o      = IDXW'(RATIO - 1);
      final_o     = IDXW'(RATIO - 1);
      found_first = 1'b0;
      found_next  = 1'b0;
      for (int k = 0; k < RATIO; k++) begin
         if (nz_i[k]) begin
            if (!found_first) begin
               first_o     = IDXW'(k);
               found_first = 1'b1;
            end
            if (!found_next && (k > int'(idx_i))) begin
               next_o     = IDXW'(k);
               found_next = 1'b1;
            end
            final_o = IDXW'(k);
         end
      end
   end
endmodule

// File: rtl/axi_stream_downsizer.sv
// Splits each wide AXI-Stream beat into RATIO little-endian narrow beats (AXIS_DOWNSIZER_NULL_SKIP_EN skips empty slices).
// Latency: first slice valid one cycle after accept; back-to-back wide beats stream with no bubble.
// Backpressure: outputs hold while m.tready is low; s.tready only on EMPTY or on the consumed final slice.
module axi_stream_downsizer
   import axi_stream_pkg::*;
#(
   parameter int IN_BYTE_WIDTH  = 4,
   parameter int OUT_BYTE_WIDTH = 1,
   parameter int ID_WIDTH       = 0,
   parameter int DEST_WIDTH     = 0,
   parameter int USER_WIDTH     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   axi_stream_downsizer_if.slave  s,
   axi_stream_downsizer_if.master m
);
   localparam int RATIO = ratio(IN_BYTE_WIDTH, OUT_BYTE_WIDTH);
   localparam int IDXW  = idx_width(RATIO);
   localparam int OBW   = 8 * OUT_BYTE_WIDTH;
   localparam int IW    = side_width(ID_WIDTH);
   localparam int DW    = side_width(DEST_WIDTH);
   localparam int UW    = side_width(USER_WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

   if (!widths_ok(IN_BYTE_WIDTH, OUT_BYTE_WIDTH)) begin : g_bad_widths
      $error("IN_BYTE_WIDTH must be a nonzero multiple of a nonzero OUT_BYTE_WIDTH");
   end

   state_t                     state_q;
   logic [IDXW-1:0]            idx_q;
   logic [8*IN_BYTE_WIDTH-1:0] h_dat_q;
   logic [IN_BYTE_WIDTH-1:0]   h_strb_q;
   logic [IN_BYTE_WIDTH-1:0]   h_keep_q;
   logic                       h_last_q;
   logic [IW-1:0]              h_id_q;
   logic [DW-1:0]              h_dest_q;
   logic [UW-1:0]              h_user_q;

   logic [IDXW-1:0] first_idx;
   logic [IDXW-1:0] next_idx;
   logic [IDXW-1:0] final_idx;
   logic            drop_beat;
   logic            is_final;
   logic            s_rdy;
   logic            s_acc;
   logic            m_xfer;

`ifdef AXIS_DOWNSIZER_NULL_SKIP_EN
   logic [RATIO-1:0] in_nz;
   logic [RATIO-1:0] h_nz;
   logic [IDXW-1:0]  unused_in_next;
   logic [IDXW-1:0]  unused_in_final;
   logic [IDXW-1:0]  unused_h_first;

   // A slice is occupied when any of its keep bits is set.
   always_comb begin
      in_nz = '0;
      h_nz  = '0;
      for (int k = 0; k < RATIO; k++) begin
         in_nz[k] = |s.tkeep[k*OUT_BYTE_WIDTH +: OUT_BYTE_WIDTH];
         h_nz[k]  = |h_keep_q[k*OUT_BYTE_WIDTH +: OUT_BYTE_WIDTH];
      end
   end

   // Incoming beat decides where emission starts.
   axis_slice_finder #(.RATIO(RATIO), .IDXW(IDXW)) u_in_finder (
      .nz_i    (in_nz),
      .idx_i   ({IDXW{1'b0}}),
      .first_o (first_idx),
      .next_o  (unused_in_next),
      .final_o (unused_in_final)
   );

   // Held beat decides where emission advances to and where it stops.
   axis_slice_finder #(.RATIO(RATIO), .IDXW(IDXW)) u_h_finder (
      .nz_i    (h_nz),
      .idx_i   (idx_q),
      .first_o (unused_h_first),
      .next_o  (next_idx),
      .final_o (final_idx)
   );

   // Empty non-terminal beats carry nothing worth emitting.
   assign drop_beat = ~(|in_nz) & ~s.tlast;
`else
   assign first_idx = '0;
   assign next_idx  = idx_q + 1'b1;
   assign final_idx = LAST_IDX;
   assign drop_beat = 1'b0;
`endif

   assign is_final = (idx_q == final_idx);
   assign s_rdy    = !reset && ((state_q == ST_EMPTY) || (m.tready && is_final));
   assign s_acc    = s.tvalid && s_rdy;
   assign m_xfer   = (state_q == ST_BUSY) && m.tready;

   // Holding register, slice index and EMPTY/BUSY state; a final-slice transfer with a
   // simultaneous accept reloads directly so wide beats stream without a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         idx_q    <= '0;
         h_dat_q  <= '0;
         h_strb_q <= '0;
         h_keep_q <= '0;
         h_last_q <= 1'b0;
         h_id_q   <= '0;
         h_dest_q <= '0;
         h_user_q <= '0;
      end else if (s_acc) begin
         h_dat_q  <= s.tdata;
         h_strb_q <= s.tstrb;
         h_keep_q <= s.tkeep;
         h_last_q <= s.tlast;
         h_id_q   <= (ID_WIDTH   > 0) ? s.tid   : '0;
         h_dest_q <= (DEST_WIDTH > 0) ? s.tdest : '0;
         h_user_q <= (USER_WIDTH > 0) ? s.tuser : '0;
         idx_q    <= first_idx;
         state_q  <= drop_beat ? ST_EMPTY : ST_BUSY;
      end else if (m_xfer) begin
         if (is_final) begin
            state_q <= ST_EMPTY;
         end else begin
            idx_q <= next_idx;
         end
      end
   end

   assign s.tready = s_rdy;
   assign m.tvalid = (state_q == ST_BUSY);
   assign m.tdata  = h_dat_q[idx_q*OBW +: OBW];
   assign m.tstrb  = h_strb_q[idx_q*OUT_BYTE_WIDTH +: OUT_BYTE_WIDTH];
   assign m.tkeep  = h_keep_q[idx_q*OUT_BYTE_WIDTH +: OUT_BYTE_WIDTH];
   assign m.tlast  = h_last_q && is_final;
   assign m.tid    = h_id_q;
   assign m.tdest  = h_dest_q;
   assign m.tuser  = h_user_q;

endmodule

// File: tb/tb_axi_stream_downsizer.sv
// Bench for the downsizer: a 4->1 instance and a 4->2 instance with sidebands, random traffic.
// Latency: checks the one-cycle accept-to-valid latency and bubble-free streaming.
// Backpressure: random m_tready with stall-stability checks on every cycle.
module tb_axi_stream_downsizer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] dat;
      logic [7:0]  strb;
      logic [7:0]  keep;
      logic        last;
      logic [7:0]  user;
      logic [7:0]  id;
      logic [7:0]  dest;
   } slc_t;

   slc_t q0[$];
   slc_t q1[$];
   slc_t log0[$];
   slc_t log1[$];
   int   logc0[$];

   logic        s_vld [2];
   logic [31:0] s_dat [2];
   logic [3:0]  s_keep[2];
   logic [3:0]  s_strb[2];
   logic        s_last[2];
   logic [2:0]  s_user[2];
   logic [1:0]  s_id  [2];
   logic [1:0]  s_dest[2];
   logic        m_rdy [2];
   logic        rnd_rdy[2];

   logic        s_rdy [2];
   logic        m_vld [2];
   logic        m_last[2];
   logic [63:0] m_dat [2];
   logic [7:0]  m_strb[2];
   logic [7:0]  m_keep[2];
   logic [7:0]  m_user[2];
   logic [7:0]  m_id  [2];
   logic [7:0]  m_dest[2];

   logic        prev_stall[2];
   slc_t        prev_out[2];

   axi_stream_downsizer_if #(.BYTE_WIDTH(4)) sif0();
   axi_stream_downsizer_if #(.BYTE_WIDTH(1)) mif0();
   axi_stream_downsizer_if #(.BYTE_WIDTH(4), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(3)) sif1();
   axi_stream_downsizer_if #(.BYTE_WIDTH(2), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(3)) mif1();

   assign sif0.tvalid = s_vld[0];
   assign sif0.tdata  = s_dat[0];
   assign sif0.tkeep  = s_keep[0];
   assign sif0.tstrb  = s_strb[0];
   assign sif0.tlast  = s_last[0];
   assign sif0.tid    = 1'b0;
   assign sif0.tdest  = 1'b0;
   assign sif0.tuser  = 1'b0;
   assign mif0.tready = m_rdy[0];
   assign s_rdy[0]    = sif0.tready;
   assign m_vld[0]    = mif0.tvalid;
   assign m_last[0]   = mif0.tlast;
   assign m_dat[0]    = {56'b0, mif0.tdata};
   assign m_strb[0]   = {7'b0, mif0.tstrb};
   assign m_keep[0]   = {7'b0, mif0.tkeep};
   assign m_user[0]   = {7'b0, mif0.tuser};
   assign m_id[0]     = {7'b0, mif0.tid};
   assign m_dest[0]   = {7'b0, mif0.tdest};

   assign sif1.tvalid = s_vld[1];
   assign sif1.tdata  = s_dat[1];
   assign sif1.tkeep  = s_keep[1];
   assign sif1.tstrb  = s_strb[1];
   assign sif1.tlast  = s_last[1];
   assign sif1.tid    = s_id[1];
   assign sif1.tdest  = s_dest[1];
   assign sif1.tuser  = s_user[1];
   assign mif1.tready = m_rdy[1];
   assign s_rdy[1]    = sif1.tready;
   assign m_vld[1]    = mif1.tvalid;
   assign m_last[1]   = mif1.tlast;
   assign m_dat[1]    = {48'b0, mif1.tdata};
   assign m_strb[1]   = {6'b0, mif1.tstrb};
   assign m_keep[1]   = {6'b0, mif1.tkeep};
   assign m_user[1]   = {5'b0, mif1.tuser};
   assign m_id[1]     = {6'b0, mif1.tid};
   assign m_dest[1]   = {6'b0, mif1.tdest};

   axi_stream_downsizer #(.IN_BYTE_WIDTH(4), .OUT_BYTE_WIDTH(1)) dut0 (
      .clk(clk), .reset(reset), .s(sif0), .m(mif0)
   );

   axi_stream_downsizer #(.IN_BYTE_WIDTH(4), .OUT_BYTE_WIDTH(2), .ID_WIDTH(2),
                          .DEST_WIDTH(2), .USER_WIDTH(3)) dut1 (
      .clk(clk), .reset(reset), .s(sif1), .m(mif1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a wide beat becomes the list of narrow slices it must produce.
   function automatic void push_beat(input int d, input logic [31:0] dat, input logic [3:0] keep,
                                     input logic [3:0] strb, input logic last, input logic [7:0] user,
                                     input logic [7:0] id, input logic [7:0] dest);
      int   r;
      int   ob;
      slc_t lst[$];
      slc_t e;
      r  = (d == 0) ? 4 : 2;
      ob = (d == 0) ? 1 : 2;
      for (int k = 0; k < r; k++) begin
         e.dat  = (64'(dat) >> (8*ob*k)) & ((64'd1 << (8*ob)) - 64'd1);
         e.keep = 8'((32'(keep) >> (ob*k)) & ((32'd1 << ob) - 32'd1));
         e.strb = 8'((32'(strb) >> (ob*k)) & ((32'd1 << ob) - 32'd1));
         e.last = 1'b0;
         e.user = user;
         e.id   = id;
         e.dest = dest;
`ifdef AXIS_DOWNSIZER_NULL_SKIP_EN
         if (e.keep != 8'd0) lst.push_back(e);
         if ((k == r - 1) && (lst.size() == 0) && last) lst.push_back(e);
`else
         lst.push_back(e);
`endif
      end
      if (lst.size() > 0) begin
         e = lst.pop_back();
         e.last = last;
         lst.push_back(e);
      end
      foreach (lst[i]) begin
         if (d == 0) q0.push_back(lst[i]);
         else        q1.push_back(lst[i]);
      end
   endfunction

   // Per-cycle comparison; runs on the falling edge, decisions take effect at the next rise.
   task automatic step(input int d);
      slc_t  qq[$];
      slc_t  e;
      slc_t  cur;
      string nm;
      nm = (d == 0) ? "d0" : "d1";
      if (d == 0) qq = q0; else qq = q1;
      cur.dat = m_dat[d]; cur.strb = m_strb[d]; cur.keep = m_keep[d]; cur.last = m_last[d];
      cur.user = m_user[d]; cur.id = m_id[d]; cur.dest = m_dest[d];

      chk({nm, "_s_tready"}, 64'(s_rdy[d]),
          64'(!reset && ((qq.size() == 0) || (m_rdy[d] && (qq.size() == 1)))));
      chk({nm, "_m_tvalid"}, 64'(m_vld[d]), 64'(qq.size() > 0));

      if (prev_stall[d] && !reset) begin
         chk({nm, "_stall_vld"},  64'(m_vld[d]), 64'd1);
         chk({nm, "_stall_dat"},  cur.dat, prev_out[d].dat);
         chk({nm, "_stall_keep"}, {cur.strb, cur.keep, 7'b0, cur.last},
                                   {prev_out[d].strb, prev_out[d].keep, 7'b0, prev_out[d].last});
      end

      if (reset) begin
         qq.delete();
         if (d == 0) q0 = qq; else q1 = qq;
      end else begin
         if (m_vld[d] && m_rdy[d] && (qq.size() > 0)) begin
            e = qq.pop_front();
            chk({nm, "_tdata"}, cur.dat, e.dat);
            chk({nm, "_tstrb_tkeep"}, {cur.strb, cur.keep}, {e.strb, e.keep});
            chk({nm, "_tlast"}, 64'(cur.last), 64'(e.last));
            chk({nm, "_side"}, {cur.user, cur.id, cur.dest}, {e.user, e.id, e.dest});
            if (d == 0) begin log0.push_back(cur); logc0.push_back(cyc); end
            else        log1.push_back(cur);
         end
         if (d == 0) q0 = qq; else q1 = qq;
         if (s_vld[d] && s_rdy[d])
            push_beat(d, s_dat[d], s_keep[d], s_strb[d], s_last[d],
                      (d == 0) ? 8'd0 : 8'(s_user[d]), (d == 0) ? 8'd0 : 8'(s_id[d]),
                      (d == 0) ? 8'd0 : 8'(s_dest[d]));
      end
      prev_stall[d] = !reset && m_vld[d] && !m_rdy[d];
      prev_out[d]   = cur;
   endtask

   always @(negedge clk) begin
      step(0);
      step(1);
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++)
         if (rnd_rdy[d]) m_rdy[d] = ($urandom_range(0, 3) != 0);
   end

   int acc_cyc;

   task automatic send(input int d, input logic [31:0] dat, input logic [3:0] keep,
                       input logic [3:0] strb, input logic last, input logic [2:0] user,
                       input logic [1:0] id, input logic [1:0] dest);
      int n;
      s_vld[d] = 1'b1; s_dat[d] = dat; s_keep[d] = keep; s_strb[d] = strb;
      s_last[d] = last; s_user[d] = user; s_id[d] = id; s_dest[d] = dest;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (s_rdy[d]) break;
      end
      if (n == 300) begin
         checks++; errors++;
         $display("FAIL send_timeout d%0d: got no s_tready expected accept within 300 cycles", d);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      s_vld[d] = 1'b0;
   endtask

   task automatic rand_phase(input int d, input int n);
      logic [3:0] kp;
      rnd_rdy[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         kp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         send(d, $urandom, kp, 4'($urandom) & kp, 1'($urandom), 3'($urandom), 2'($urandom),
              2'($urandom));
      end
      rnd_rdy[d] = 1'b0;
      m_rdy[d]   = 1'b1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         s_vld[d] = 0; s_dat[d] = 0; s_keep[d] = 0; s_strb[d] = 0; s_last[d] = 0;
         s_user[d] = 0; s_id[d] = 0; s_dest[d] = 0; m_rdy[d] = 0; rnd_rdy[d] = 0;
         prev_stall[d] = 0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_m_tvalid", 64'(m_vld[d]), 64'd0);
         chk("reset_s_tready", 64'(s_rdy[d]), 64'd0);
         chk("reset_m_bus", {m_dat[d][31:0], m_keep[d], m_strb[d], 7'b0, m_last[d], m_user[d]}, 64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;

      // 4->1 single packet beat
      m_rdy[0] = 1'b1;
      log0.delete(); logc0.delete();
      send(0, 32'h44332211, 4'hF, 4'hF, 1'b1, 0, 0, 0);
      repeat (6) @(posedge clk); #1;
      chk("t1_count", 64'(log0.size()), 64'd4);
      if (log0.size() == 4) begin
         chk("t1_beats", {log0[0].dat[7:0], log0[1].dat[7:0], log0[2].dat[7:0], log0[3].dat[7:0]},
             64'h11223344);
         chk("t1_lasts", {log0[0].last, log0[1].last, log0[2].last, log0[3].last}, 64'b0001);
         chk("t1_first_latency", 64'(logc0[0]), 64'(acc_cyc));
      end

      // back-to-back beats, no bubble
      log0.delete(); logc0.delete();
      send(0, 32'hA3A2A1A0, 4'hF, 4'hF, 1'b0, 0, 0, 0);
      send(0, 32'hB3B2B1B0, 4'hF, 4'hF, 1'b1, 0, 0, 0);
      repeat (10) @(posedge clk); #1;
      chk("t2_count", 64'(log0.size()), 64'd8);
      if (log0.size() == 8) begin
         chk("t2_beats", {log0[0].dat[7:0], log0[1].dat[7:0], log0[2].dat[7:0], log0[3].dat[7:0],
                          log0[4].dat[7:0], log0[5].dat[7:0], log0[6].dat[7:0], log0[7].dat[7:0]},
             64'hA0A1A2A3B0B1B2B3);
         chk("t2_no_bubble", 64'(logc0[7] - logc0[0]), 64'd7);
         chk("t2_last_pos", {log0[3].last, log0[7].last}, 64'b01);
      end

      // stall on 0x22
      m_rdy[0] = 1'b0;
      send(0, 32'h44332211, 4'hF, 4'hF, 1'b1, 0, 0, 0);
      m_rdy[0] = 1'b1;
      @(posedge clk); #1;
      m_rdy[0] = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("t3_hold", {m_dat[0][7:0], 7'b0, m_vld[0], 7'b0, s_rdy[0]}, {8'h22, 8'h01, 8'h00});
      end
      @(posedge clk); #1;
      m_rdy[0] = 1'b1;
      repeat (6) @(posedge clk); #1;

      // reset mid-beat discards the rest
      log0.delete();
      send(0, 32'h44332211, 4'hF, 4'hF, 1'b1, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t4_after_reset", {7'b0, m_vld[0], 7'b0, s_rdy[0], m_dat[0][7:0]}, 64'd0);
      chk("t4_sent_11", {32'(log0.size()), 24'b0, (log0.size() > 0) ? log0[0].dat[7:0] : 8'h00},
          {32'd1, 24'b0, 8'h11});
      reset = 1'b0;
      log0.delete();
      repeat (10) @(posedge clk); #1;
      chk("t4_no_residue", 64'(log0.size()), 64'd0);

`ifdef AXIS_DOWNSIZER_NULL_SKIP_EN
      log0.delete();
      send(0, 32'h44332211, 4'b0110, 4'b0110, 1'b1, 0, 0, 0);
      repeat (5) @(posedge clk); #1;
      chk("t5_skip_count", 64'(log0.size()), 64'd2);
      if (log0.size() == 2)
         chk("t5_skip_beats", {log0[0].dat[7:0], 7'b0, log0[0].last, log0[1].dat[7:0], 7'b0, log0[1].last},
             {8'h22, 8'h00, 8'h33, 8'h01});
      log0.delete();
      send(0, 32'h44332211, 4'b0000, 4'b0000, 1'b1, 0, 0, 0);
      send(0, 32'h55667788, 4'b0000, 4'b0000, 1'b0, 0, 0, 0);
      repeat (5) @(posedge clk); #1;
      chk("t5_empty_count", 64'(log0.size()), 64'd1);
      if (log0.size() == 1)
         chk("t5_empty_beat", {log0[0].keep, 7'b0, log0[0].last}, {8'h00, 8'h01});
`endif

      // 4->2 with sidebands
      m_rdy[1] = 1'b1;
      log1.delete();
      send(1, 32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 3'd5, 2'd2, 2'd1);
      repeat (4) @(posedge clk); #1;
      chk("t6_count", 64'(log1.size()), 64'd2);
      if (log1.size() == 2) begin
         chk("t6_beats", {log1[0].dat[15:0], log1[1].dat[15:0]}, 64'hBBAADDCC);
         chk("t6_user", {log1[0].user, log1[1].user, log1[0].id, log1[1].dest}, 64'h05050201);
         chk("t6_lasts", {log1[0].last, log1[1].last}, 64'b01);
      end

      fork
         rand_phase(0, 200);
         rand_phase(1, 200);
      join

      for (int n = 0; n < 200 && (q0.size() + q1.size() > 0); n++) @(posedge clk);
      @(negedge clk);
      chk("drain", 64'(q0.size() + q1.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
